fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction fetch stage with the fetch/decode (FD) pipeline register, directly upstream of hazard detection and decode.
- Issues one instruction-memory request at a time over a req/gnt/rvalid handshake and tracks the PC.
- Holds FD while the hazard unit's bubble (stall_i) is asserted.
- Discards wrong-path work on a branch/jump redirect from execute.

Parameters:
INSTR_W, 16, instruction width in bits
PC_W, 10, PC / instruction-memory word-address width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
stall_i  in  1  bubble from hazard detection; FD register must hold
flush_i  in  1  redirect valid (taken branch/jump)
redirect_pc_i  in  PC_W  redirect target, sampled when flush_i=1
imem_req_o  out  1  fetch request valid
imem_addr_o  out  PC_W  fetch word address
imem_gnt_i  in  1  request accepted in the cycle req && gnt
imem_rvalid_i  in  1  response valid; one per granted request, at least 1 cycle after gnt
imem_rdata_i  in  INSTR_W  response instruction
instruction_fd_o  out  INSTR_W  FD instruction
pc_fd_o  out  PC_W  PC of instruction_fd_o
valid_fd_o  out  1  FD holds a real instruction (0 = bubble/NOP)

Behaviour:
- Reset (synchronous, any state or mid-transaction): pc_r=RESET_PC, state=IDLE, valid_fd_o=0, instruction_fd_o=0, pc_fd_o=0, hold buffer empty. imem_req_o=0 while in IDLE.
- Responses already in flight when reset is applied are ignored: state IDLE does not track rvalid.
- State machine (4 states):
  - IDLE -> REQ next cycle, unconditionally.
  - REQ: imem_req_o=1, imem_addr_o=pc_r. On gnt: pc_inflight<=pc_r, pc_r<=pc_r+1 (wraps modulo 2^PC_W), go to WAIT.
  - REQ stays REQ if the hold buffer is full; imem_req_o=0 in that case.
  - WAIT: on rvalid, deliver the response (see delivery rules), then go to REQ.
  - DROP: an outstanding response is to be discarded. On rvalid, discard it and go to REQ.
- Delivery rules:
  - FD accepts when stall_i=0.
  - If FD accepts: instruction_fd_o<=rdata, pc_fd_o<=pc_inflight, valid_fd_o<=1.
  - If stall_i=1: the response goes to a 1-entry hold buffer (data + pc).
  - When the hold buffer is full and stall_i=0, the buffer drains into FD first.
  - FD with no new instruction and stall_i=0: valid_fd_o<=0. instruction_fd_o and pc_fd_o keep their old values.
  - stall_i=1: all FD outputs hold, including valid_fd_o.
- Flush (highest priority after reset):
  - Next cycle: valid_fd_o=0, hold buffer empty, pc_r=redirect_pc_i.
  - Flush in WAIT, or in REQ with gnt in the same cycle: go to DROP.
  - Flush in DROP: stay in DROP and update pc_r.
  - Flush in REQ without gnt, or in IDLE: go to REQ.
  - Flush in the same cycle as rvalid in WAIT: the response is discarded and the state goes to REQ.
- Flush and stall together: flush wins.
- Latency:
  - With gnt in the request cycle and rvalid 1 cycle later, the instruction is visible in FD 2 cycles after req.
  - Peak throughput is 1 instruction per 2 cycles.
- Never more than one outstanding request. rvalid in IDLE or REQ is a protocol error and is ignored.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds output ports stall_cnt_o [31:0] and fetch_cnt_o [31:0].
  - stall_cnt_o counts cycles with stall_i=1.
  - fetch_cnt_o counts instructions loaded into FD with valid=1.
  - Both counters clear on reset and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
1. Reset with RESET_PC=0; memory grants immediately, rvalid 1 cycle later, mem[i]=16'h1000+i -> first req addr 0 at cycle 1. FD shows (16'h1000, pc 0, valid 1) at cycle 3, then (16'h1001, pc 1) 2 cycles later.
2. stall_i=1 for 4 cycles while FD holds pc 2 and the pc 3 response arrives -> FD holds pc 2, pc 3 goes to the hold buffer, and imem_req_o=0 while the buffer is full. Stall released -> pc 3 in FD the next cycle, fetch resumes at pc 4.
3. flush_i with redirect_pc_i=10'h040 while WAIT for pc 5 -> valid_fd_o=0 next cycle, the pc 5 rdata is discarded, next req addr 10'h040.
4. flush_i in the same cycle as rvalid and stall_i=1 -> response dropped, valid_fd_o=0, hold buffer empty, next req at the redirect target.
5. PC wrap: RESET_PC=10'h3FF -> fetch addr 3FF, then addr 000.
6. Reset asserted during WAIT -> outputs return to reset values, and a stale rvalid in the next cycle does not load FD. With FETCH_PERF_CNT_EN, counters read 0 after reset and fetch_cnt_o=3 after 3 delivered instructions.

Source files
------------

// File: rtl/fetch_stage.sv
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch with a req/gnt/rvalid memory port, a
//                one-entry hold buffer and the FD pipeline register.
//                Optional macro FETCH_PERF_CNT_EN adds stall/fetch counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter int              INSTR_W  = 16,
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [INSTR_W-1:0] instruction_fd_o,
    output logic [PC_W-1:0]    pc_fd_o,
    output logic               valid_fd_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt_o,
    output logic [31:0]        fetch_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] c_pc_one = {{(PC_W-1){1'b0}}, 1'b1};

    state_t               r_state;
    logic [PC_W-1:0]      r_pc;
    logic [PC_W-1:0]      r_pc_inflight;
    logic                 r_hold_valid;
    logic [INSTR_W-1:0]   r_hold_instr;
    logic [PC_W-1:0]      r_hold_pc;

    logic                 w_fire;
    logic                 w_resp;
    logic                 w_fd_load;

    // No new request while a stalled response is parked in the hold buffer
    assign imem_req_o  = (r_state == ST_REQ) && !r_hold_valid;
    assign imem_addr_o = r_pc;
    assign w_fire      = imem_req_o && imem_gnt_i;
    assign w_resp      = (r_state == ST_WAIT) && imem_rvalid_i;
    assign w_fd_load   = !reset && !flush_i && !stall_i && (r_hold_valid || w_resp);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_pc             <= RESET_PC;
            r_pc_inflight    <= '0;
            r_hold_valid     <= 1'b0;
            r_hold_instr     <= '0;
            r_hold_pc        <= '0;
            instruction_fd_o <= '0;
            pc_fd_o          <= '0;
            valid_fd_o       <= 1'b0;
        end else if (flush_i) begin
            r_pc         <= redirect_pc_i;
            valid_fd_o   <= 1'b0;
            r_hold_valid <= 1'b0;
            // A granted-but-unanswered request must be drained in DROP
            case (r_state)
                ST_IDLE: r_state <= ST_REQ;
                ST_REQ:  r_state <= w_fire ? ST_DROP : ST_REQ;
                ST_WAIT: r_state <= imem_rvalid_i ? ST_REQ : ST_DROP;
                ST_DROP: r_state <= imem_rvalid_i ? ST_REQ : ST_DROP;
                default: r_state <= ST_IDLE;
            endcase
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_REQ;
                ST_REQ: begin
                    if (w_fire) begin
                        r_pc_inflight <= r_pc;
                        r_pc          <= r_pc + c_pc_one;
                        r_state       <= ST_WAIT;
                    end
                end
                ST_WAIT: if (imem_rvalid_i) r_state <= ST_REQ;
                ST_DROP: if (imem_rvalid_i) r_state <= ST_REQ;
                default: r_state <= ST_IDLE;
            endcase

            if (!stall_i) begin
                if (r_hold_valid) begin
                    instruction_fd_o <= r_hold_instr;
                    pc_fd_o          <= r_hold_pc;
                    valid_fd_o       <= 1'b1;
                    r_hold_valid     <= 1'b0;
                end else if (w_resp) begin
                    instruction_fd_o <= imem_rdata_i;
                    pc_fd_o          <= r_pc_inflight;
                    valid_fd_o       <= 1'b1;
                end else begin
                    valid_fd_o <= 1'b0;
                end
            end else if (w_resp) begin
                // Responses only arrive with the buffer empty (no request while full)
                r_hold_instr <= imem_rdata_i;
                r_hold_pc    <= r_pc_inflight;
                r_hold_valid <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_o <= '0;
            fetch_cnt_o <= '0;
        end else begin
            if (stall_i)   stall_cnt_o <= stall_cnt_o + 32'd1;
            if (w_fd_load) fetch_cnt_o <= fetch_cnt_o + 32'd1;
        end
    end
`else
    logic w_unused;
    assign w_unused = w_fd_load;
`endif

endmodule

`default_nettype wire
